// File: rtl/control_sequencer.sv
// Instruction-cycle sequencer for the RichieJr core: a fixed six-state T-cycle
// (three fetch, three execute) that decodes the opcode into one control word per state.
module control_sequencer #(
  parameter int             OP_W   = 4,
  parameter logic [OP_W-1:0] OP_LDA = 4'h0,
  parameter logic [OP_W-1:0] OP_ADD = 4'h1,
  parameter logic [OP_W-1:0] OP_SUB = 4'h2,
  parameter logic [OP_W-1:0] OP_OUT = 4'hE,
  parameter logic [OP_W-1:0] OP_HLT = 4'hF
) (
  input  logic            clk,
  input  logic            res,
  input  logic            run,
  input  logic [OP_W-1:0] opcode,
  output logic [2:0]      tstate,
  output logic            halt,
  output logic            pc_en,
  output logic            pc_oe,
  output logic            mar_ld,
  output logic            ram_oe,
  output logic            ir_ld,
  output logic            ir_oe,
  output logic            a_ld,
  output logic            a_oe,
  output logic            b_ld,
  output logic            alu_oe,
  output logic            alu_sub,
  output logic            out_ld
);

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4,
    T5 = 3'd5
  } tstate_e;

  tstate_e state, state_next;
  logic    halted, halted_next;

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state  <= T0;
      halted <= 1'b0;
    end else begin
      state  <= state_next;
      halted <= halted_next;
    end
  end

  // HLT is taken on the edge ending T3; once halted the sequencer is frozen at T0.
  always_comb begin
    state_next  = state;
    halted_next = halted;
    if (run && !halted) begin
      unique case (state)
        T0:      state_next = T1;
        T1:      state_next = T2;
        T2:      state_next = T3;
        T3: begin
          if (opcode == OP_HLT) begin
            state_next  = T0;
            halted_next = 1'b1;
          end else begin
            state_next = T4;
          end
        end
        T4:      state_next = T5;
        T5:      state_next = T0;
        default: state_next = T0;
      endcase
    end
  end

  always_comb begin
    pc_en   = 1'b0;
    pc_oe   = 1'b0;
    mar_ld  = 1'b0;
    ram_oe  = 1'b0;
    ir_ld   = 1'b0;
    ir_oe   = 1'b0;
    a_ld    = 1'b0;
    a_oe    = 1'b0;
    b_ld    = 1'b0;
    alu_oe  = 1'b0;
    alu_sub = 1'b0;
    out_ld  = 1'b0;
    if (res && run && !halted) begin
      unique case (state)
        T0: begin
          pc_oe  = 1'b1;
          mar_ld = 1'b1;
        end
        T1: pc_en = 1'b1;
        T2: begin
          ram_oe = 1'b1;
          ir_ld  = 1'b1;
        end
        T3: begin
          if (opcode == OP_LDA || opcode == OP_ADD || opcode == OP_SUB) begin
            ir_oe  = 1'b1;
            mar_ld = 1'b1;
          end else if (opcode == OP_OUT) begin
            a_oe   = 1'b1;
            out_ld = 1'b1;
          end
        end
        T4: begin
          if (opcode == OP_LDA) begin
            ram_oe = 1'b1;
            a_ld   = 1'b1;
          end else if (opcode == OP_ADD || opcode == OP_SUB) begin
            ram_oe = 1'b1;
            b_ld   = 1'b1;
          end
        end
        T5: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_oe  = 1'b1;
            a_ld    = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  assign tstate = state;
  assign halt   = halted;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: directed instruction walks with literal
// control words, plus randomized stimulus compared every cycle against a behavioural model.
module tb_control_sequencer;

  logic       clk;
  logic       res;
  logic       run;
  logic [3:0] opcode;
  logic [2:0] tstate;
  logic       halt;
  logic       pc_en, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe;
  logic       a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld;

  int checks = 0;
  int errors = 0;
  bit compare_on = 0;

  // Control word packing: {pc_en,pc_oe,mar_ld,ram_oe,ir_ld,ir_oe,a_ld,a_oe,b_ld,alu_oe,alu_sub,out_ld}
  localparam logic [11:0] W_PC_EN   = 12'h800;
  localparam logic [11:0] W_PC_OE   = 12'h400;
  localparam logic [11:0] W_MAR_LD  = 12'h200;
  localparam logic [11:0] W_RAM_OE  = 12'h100;
  localparam logic [11:0] W_IR_LD   = 12'h080;
  localparam logic [11:0] W_IR_OE   = 12'h040;
  localparam logic [11:0] W_A_LD    = 12'h020;
  localparam logic [11:0] W_A_OE    = 12'h010;
  localparam logic [11:0] W_B_LD    = 12'h008;
  localparam logic [11:0] W_ALU_OE  = 12'h004;
  localparam logic [11:0] W_ALU_SUB = 12'h002;
  localparam logic [11:0] W_OUT_LD  = 12'h001;

  wire [11:0] ctl = {pc_en, pc_oe, mar_ld, ram_oe, ir_ld, ir_oe,
                     a_ld, a_oe, b_ld, alu_oe, alu_sub, out_ld};
  wire [4:0]  drivers = {pc_oe, ram_oe, ir_oe, a_oe, alu_oe};

  control_sequencer dut (
    .clk(clk), .res(res), .run(run), .opcode(opcode),
    .tstate(tstate), .halt(halt),
    .pc_en(pc_en), .pc_oe(pc_oe), .mar_ld(mar_ld), .ram_oe(ram_oe),
    .ir_ld(ir_ld), .ir_oe(ir_oe), .a_ld(a_ld), .a_oe(a_oe),
    .b_ld(b_ld), .alu_oe(alu_oe), .alu_sub(alu_sub), .out_ld(out_ld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: instruction step counter and halted flag.
  int mdl_t = 0;
  bit mdl_halt = 0;

  always @(posedge clk or negedge res) begin
    if (!res) begin
      mdl_t    = 0;
      mdl_halt = 0;
    end else if (run && !mdl_halt) begin
      if (mdl_t == 3 && opcode == 4'hF) begin
        mdl_halt = 1;
        mdl_t    = 0;
      end else begin
        mdl_t = (mdl_t + 1) % 6;
      end
    end
  end

  function automatic logic [11:0] model_word(int t, logic [3:0] op, bit h, logic r, logic rn);
    logic [11:0] exec [3];
    if (!r || !rn || h) return 12'h000;
    exec[0] = 12'h000; exec[1] = 12'h000; exec[2] = 12'h000;
    case (op)
      4'h0: begin exec[0] = W_IR_OE | W_MAR_LD; exec[1] = W_RAM_OE | W_A_LD; end
      4'h1: begin exec[0] = W_IR_OE | W_MAR_LD; exec[1] = W_RAM_OE | W_B_LD;
                  exec[2] = W_ALU_OE | W_A_LD; end
      4'h2: begin exec[0] = W_IR_OE | W_MAR_LD; exec[1] = W_RAM_OE | W_B_LD;
                  exec[2] = W_ALU_OE | W_A_LD | W_ALU_SUB; end
      4'hE: exec[0] = W_A_OE | W_OUT_LD;
      default: ;
    endcase
    case (t)
      0: return W_PC_OE | W_MAR_LD;
      1: return W_PC_EN;
      2: return W_RAM_OE | W_IR_LD;
      default: return exec[t-3];
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (compare_on) begin
      checkOutput("model_tstate", 32'(tstate), 32'(mdl_t));
      checkOutput("model_halt", 32'(halt), 32'(mdl_halt));
      checkOutput("model_ctl", 32'(ctl), 32'(model_word(mdl_t, opcode, mdl_halt, res, run)));
      checkOutput("one_bus_driver", 32'($countones(drivers) <= 1), 32'd1);
    end
  end

  // Called at a falling edge: drive inputs just after it, then wait one full clock.
  task automatic applyStimulus(input logic r, input logic [3:0] op);
    #1;
    run    = r;
    opcode = op;
    @(negedge clk);
  endtask

  task automatic releaseReset(input logic [3:0] op);
    @(posedge clk);
    #1;
    res    = 1'b1;
    run    = 1'b1;
    opcode = op;
    @(negedge clk);
  endtask

  task automatic walkInstruction(input logic [3:0] op, input logic [11:0] w3,
                                 input logic [11:0] w4, input logic [11:0] w5, input string tag);
    logic [11:0] exp [6];
    exp[0] = 12'h600; exp[1] = 12'h800; exp[2] = 12'h180;
    exp[3] = w3; exp[4] = w4; exp[5] = w5;
    for (int k = 1; k <= 6; k++) begin
      applyStimulus(1'b1, op);
      checkOutput({tag, "_tstate"}, 32'(tstate), 32'(k % 6));
      checkOutput({tag, "_word"}, 32'(ctl), 32'(exp[k % 6]));
    end
  endtask

  initial begin
    res    = 1'b0;
    run    = 1'b0;
    opcode = 4'h0;
    repeat (3) @(negedge clk);
    checkOutput("reset_tstate", 32'(tstate), 32'd0);
    checkOutput("reset_ctl", 32'(ctl), 32'd0);
    compare_on = 1;

    releaseReset(4'h0);
    checkOutput("lda_t0_tstate", 32'(tstate), 32'd0);
    checkOutput("lda_t0_word", 32'(ctl), 32'h600);
    walkInstruction(4'h0, 12'h240, 12'h120, 12'h000, "lda");
    walkInstruction(4'h2, 12'h240, 12'h108, 12'h026, "sub");
    walkInstruction(4'h7, 12'h000, 12'h000, 12'h000, "nop");
    walkInstruction(4'hE, 12'h011, 12'h000, 12'h000, "out");

    // ADD with run dropped for five cycles while in T4
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 4'h1);
    checkOutput("add_t4_word", 32'(ctl), 32'h108);
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1'b0, 4'h1);
      checkOutput("stall_tstate", 32'(tstate), 32'd4);
      checkOutput("stall_ctl", 32'(ctl), 32'd0);
    end
    #1 run = 1'b1;
    #1 checkOutput("resume_t4_word", 32'(ctl), 32'h108);
    checkOutput("resume_t4_tstate", 32'(tstate), 32'd4);
    @(negedge clk);
    checkOutput("add_t5_word", 32'(ctl), 32'h024);
    applyStimulus(1'b1, 4'h0);
    checkOutput("after_add_tstate", 32'(tstate), 32'd0);

    // HLT: frozen at T0 with all controls low until reset
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 4'hF);
    checkOutput("hlt_t3_word", 32'(ctl), 32'd0);
    applyStimulus(1'b1, 4'hF);
    checkOutput("hlt_flag", 32'(halt), 32'd1);
    checkOutput("hlt_tstate", 32'(tstate), 32'd0);
    for (int k = 0; k < 20; k++) begin
      applyStimulus(1'b1, 4'($urandom_range(0, 15)));
      checkOutput("halted_ctl", 32'(ctl), 32'd0);
      checkOutput("halted_tstate", 32'(tstate), 32'd0);
    end
    #1 res = 1'b0;
    #1 checkOutput("hlt_clear_flag", 32'(halt), 32'd0);
    @(negedge clk);
    releaseReset(4'h0);
    checkOutput("post_hlt_word", 32'(ctl), 32'h600);
    checkOutput("post_hlt_flag", 32'(halt), 32'd0);

    // Asynchronous reset pulse in the middle of T2
    applyStimulus(1'b1, 4'h1);
    applyStimulus(1'b1, 4'h1);
    checkOutput("pre_reset_t2_word", 32'(ctl), 32'h180);
    #2 res = 1'b0;
    #1 checkOutput("async_reset_tstate", 32'(tstate), 32'd0);
    checkOutput("async_reset_ctl", 32'(ctl), 32'd0);
    releaseReset(4'h1);
    checkOutput("async_release_word", 32'(ctl), 32'h600);

    // Randomized run/opcode traffic, occasionally resetting to escape halts
    for (int k = 0; k < 500; k++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'h7;
      applyStimulus($urandom_range(0, 7) != 0, op);
      if (k % 60 == 59) begin
        #1 res = 1'b0;
        @(negedge clk);
        releaseReset(4'($urandom_range(0, 15)));
      end
    end

    compare_on = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Instruction-cycle sequencer for the RichieJr core.
- It is the control end of the 4-bit program counter: it drives the counter's increment and output-enable, the memory address register, the instruction register and the datapath loads.
- Runs a fixed 6-state T-cycle (3 fetch, 3 execute) and decodes the current opcode into one control word per state.
- Stops permanently on HLT until reset.

Parameters:
- OP_W, 4, opcode width (upper nibble of the instruction register).
- OP_LDA, 4'h0, load accumulator from memory.
- OP_ADD, 4'h1, A <= A + mem.
- OP_SUB, 4'h2, A <= A - mem.
- OP_OUT, 4'hE, copy A to output register.
- OP_HLT, 4'hF, halt.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- res  input  1  asynchronous, active-low reset.
- run  input  1  step enable; 0 freezes the T-state and forces all controls to 0.
- opcode  input  OP_W  opcode from the instruction register; valid from T3 onward.
- tstate  output  3  current T-state, 0..5.
- halt  output  1  sticky halted flag.
- pc_en  output  1  program counter increment enable.
- pc_oe  output  1  program counter drives bus.
- mar_ld  output  1  memory address register load.
- ram_oe  output  1  memory drives bus.
- ir_ld  output  1  instruction register load.
- ir_oe  output  1  instruction register operand nibble drives bus.
- a_ld  output  1  accumulator load.
- a_oe  output  1  accumulator drives bus.
- b_ld  output  1  B register load.
- alu_oe  output  1  ALU result drives bus.
- alu_sub  output  1  ALU subtract select.
- out_ld  output  1  output register load.

Behaviour:
- State: 3-bit tstate register plus 1-bit halt register. Both clear asynchronously when res=0, and stay cleared while res=0.
- Control outputs are combinational from (tstate, opcode, halt, run, res).
  - All controls are 0 when res=0, run=0 or halt=1.
- Advance: on each rising edge with res=1, run=1, halt=0, tstate goes 0→1→2→3→4→5→0. No early termination; every instruction takes 6 cycles.
- Fetch (opcode-independent):
  - T0: pc_oe, mar_ld.
  - T1: pc_en (PC increments on the edge ending T1).
  - T2: ram_oe, ir_ld.
- Execute (T3/T4/T5):
  - LDA: ir_oe+mar_ld / ram_oe+a_ld / none.
  - ADD: ir_oe+mar_ld / ram_oe+b_ld / alu_oe+a_ld.
  - SUB: same as ADD, plus alu_sub=1 in T5 only.
  - OUT: a_oe+out_ld / none / none.
  - HLT: none in T3. On the edge ending T3, halt<=1 and tstate<=0. Thereafter tstate holds at 0 and every control is 0 until res=0.
  - Any other opcode: NOP; T3-T5 all 0, sequencing continues.
- At most one bus driver (pc_oe, ram_oe, ir_oe, a_oe, alu_oe) is high in any cycle. This is an invariant checked by the bench.
- run deasserted mid-instruction: tstate holds, controls 0. On reassertion the held state's control word reappears and sequencing resumes from there.
- Reset mid-instruction: immediate return to T0 with halt=0. First cycle after release shows the T0 word (pc_oe, mar_ld).
- opcode changes during T0-T2 have no effect on outputs.

Test Plan:
- Reset release, run=1, opcode=0: tstate sequence 0,1,2,3,4,5,0. T0 pc_oe=mar_ld=1; T1 pc_en=1 only; T2 ram_oe=ir_ld=1; T4 ram_oe=a_ld=1.
- opcode=2 (SUB) for one instruction: T5 alu_oe=a_ld=alu_sub=1; alu_sub=0 in every other state; T4 b_ld=1.
- opcode=4'hF: after T3 edge, halt=1 and tstate=0. Over 20 further cycles, all controls stay 0 and tstate stays 0. Assert res=0, then release: halt=0 and the T0 word appears.
- run=0 held 5 cycles during T4 of ADD: tstate stays 4 and controls stay 0. On run=1, ram_oe=b_ld=1, then T5 word follows.
- res pulsed low asynchronously during T2 (between edges): tstate=0 and all controls 0 immediately. After release, the T0 word appears.
- Random opcodes over 500 cycles: at most one bus driver high per cycle; opcode 4'h7 yields all-zero T3-T5.
